// File: rtl/operand_stage.sv
// operand_stage: decode-to-execute operand stage; forwards EX/MEM/WB results and stalls on load-use.
// Latency: 1 cycle from in_valid&in_ready to out_valid; throughput 1/cycle without hazards.
// Backpressure: ID/EX holds while out_ready=0 and out_valid=1; in_ready drops on stall, flush or hold.
module operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OPC_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,

  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_wr_rd,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_imm,

  // register file read port
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_reg1_data,
  input  logic [DATA_W-1:0] rf_reg2_data,

  // EX stage status
  input  logic              ex_valid,
  input  logic              ex_wr_rd,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,

  // MEM stage status
  input  logic              mem_valid,
  input  logic              mem_wr_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,

  // WB same-cycle register-file write
  input  logic              wb_write_enable,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,

  input  logic              flush,

  // ID/EX pipeline register
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_rd,
  output logic              out_is_load,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [CNT_W-1:0]  stall_count
);

  // ID/EX state
  logic              r_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [REG_AW-1:0] r_rd;
  logic              r_wr_rd;
  logic              r_is_load;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  // forwarding qualifiers: a load in EX has no data yet, so it can never forward
  logic              w_ex_can_fwd;
  logic              w_mem_can_fwd;
  logic              w_a_ex, w_a_mem, w_a_wb;
  logic              w_b_ex, w_b_mem, w_b_wb;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  // handshake / hazard
  logic              w_ex_load_wr;
  logic              w_hazard;
  logic              w_adv;
  logic              w_stall_inc;

  assign rf_read_reg1 = in_rs1;
  assign rf_read_reg2 = in_rs2;

  assign w_ex_can_fwd  = ex_valid & ex_wr_rd & ~ex_is_load;
  assign w_mem_can_fwd = mem_valid & mem_wr_rd;

  assign w_a_ex  = w_ex_can_fwd  & (ex_rd == in_rs1);
  assign w_a_mem = w_mem_can_fwd & (mem_rd == in_rs1);
  assign w_a_wb  = wb_write_enable & (wb_write_reg == in_rs1);

  assign w_b_ex  = w_ex_can_fwd  & (ex_rd == in_rs2);
  assign w_b_mem = w_mem_can_fwd & (mem_rd == in_rs2);
  assign w_b_wb  = wb_write_enable & (wb_write_reg == in_rs2);

  // Resolve each operand: youngest producer wins, RF data is the fallback.
  // WB is needed because the RF only reflects that write after the edge.
  always_comb begin
    w_op_a = rf_reg1_data;
    if (w_a_ex) begin
      w_op_a = ex_result;
    end else if (w_a_mem) begin
      w_op_a = mem_result;
    end else if (w_a_wb) begin
      w_op_a = wb_write_data;
    end

    w_op_b = rf_reg2_data;
    if (w_b_ex) begin
      w_op_b = ex_result;
    end else if (w_b_mem) begin
      w_op_b = mem_result;
    end else if (w_b_wb) begin
      w_op_b = wb_write_data;
    end
  end

  // A load in EX whose destination is read by decode must wait one cycle
  // until its data can be picked up from MEM; unused sources never stall.
  assign w_ex_load_wr = ex_valid & ex_is_load & ex_wr_rd;
  assign w_hazard     = in_valid & w_ex_load_wr &
                        ((in_use_rs1 & (ex_rd == in_rs1)) |
                         (in_use_rs2 & (ex_rd == in_rs2)));

  assign w_adv       = out_ready | ~r_valid;
  assign in_ready    = w_adv & ~w_hazard & ~flush;
  assign w_stall_inc = w_hazard & ~flush & (r_stall_cnt != {CNT_W{1'b1}});

  // ID/EX register: load when EX can take new work, hold under backpressure, flush kills valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_wr_rd   <= 1'b0;
      r_is_load <= 1'b0;
      r_imm     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
    end else if (w_adv) begin
      r_valid   <= in_valid & ~w_hazard & ~flush;
      r_opcode  <= in_opcode;
      r_rd      <= in_rd;
      r_wr_rd   <= in_wr_rd;
      r_is_load <= in_is_load;
      r_imm     <= in_imm;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
    end else if (flush) begin
      r_valid   <= 1'b0;
    end
  end

  // Saturating count of load-use stall cycles; a flushed cycle is not a stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid   = r_valid;
  assign out_opcode  = r_opcode;
  assign out_rd      = r_rd;
  assign out_wr_rd   = r_wr_rd;
  assign out_is_load = r_is_load;
  assign out_imm     = r_imm;
  assign out_op_a    = r_op_a;
  assign out_op_b    = r_op_b;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus randomized traffic.
// Expected ID/EX contents are queued at acceptance and popped by an independent monitor.
module tb_operand_stage;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready;
  logic [OW-1:0] in_opcode;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_use_rs1, in_use_rs2, in_wr_rd, in_is_load;
  logic [DW-1:0] in_imm;
  logic [AW-1:0] rf_read_reg1, rf_read_reg2;
  logic [DW-1:0] rf_reg1_data, rf_reg2_data;
  logic          ex_valid, ex_wr_rd, ex_is_load;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_result;
  logic          mem_valid, mem_wr_rd;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic          wb_write_enable;
  logic [AW-1:0] wb_write_reg;
  logic [DW-1:0] wb_write_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_opcode;
  logic [AW-1:0] out_rd;
  logic          out_wr_rd, out_is_load;
  logic [DW-1:0] out_imm, out_op_a, out_op_b;
  logic [CW-1:0] stall_count;

  operand_stage #(.DATA_W(DW), .REG_AW(AW), .OPC_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_wr_rd(in_wr_rd), .in_is_load(in_is_load), .in_imm(in_imm),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_reg1_data(rf_reg1_data), .rf_reg2_data(rf_reg2_data),
    .ex_valid(ex_valid), .ex_wr_rd(ex_wr_rd), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_wr_rd(out_wr_rd), .out_is_load(out_is_load), .out_imm(out_imm),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .stall_count(stall_count)
  );

  typedef struct {
    logic [OW-1:0] opc;
    logic [AW-1:0] rd;
    logic          wr_rd;
    logic          is_load;
    logic [DW-1:0] imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          m_valid = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference operand: scan producers from youngest to oldest; the first match wins.
  function automatic logic [DW-1:0] ref_operand(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
    logic          hit [3];
    logic [DW-1:0] val [3];
    hit[0] = ex_valid && ex_wr_rd && !ex_is_load && (ex_rd == rs);
    val[0] = ex_result;
    hit[1] = mem_valid && mem_wr_rd && (mem_rd == rs);
    val[1] = mem_result;
    hit[2] = wb_write_enable && (wb_write_reg == rs);
    val[2] = wb_write_data;
    for (int k = 0; k < 3; k++) begin
      if (hit[k]) return val[k];
    end
    return rf;
  endfunction

  // Called right after a negedge with inputs set; advances one clock and checks state.
  task automatic tick();
    logic hz, adv, acc;
    exp_t e;
    #1;
    check("rf_read_reg1", {28'd0, rf_read_reg1}, {28'd0, in_rs1});
    check("rf_read_reg2", {28'd0, rf_read_reg2}, {28'd0, in_rs2});
    if (!reset) begin
      m_valid = 1'b0;
      m_cnt   = '0;
      sb.delete();
    end else begin
      hz  = in_valid && ex_valid && ex_is_load && ex_wr_rd &&
            ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
      adv = out_ready || !m_valid;
      acc = adv && in_valid && !hz && !flush;
      check("in_ready", {31'd0, in_ready}, {31'd0, adv && !hz && !flush});
      if (acc) begin
        e.opc = in_opcode; e.rd = in_rd; e.wr_rd = in_wr_rd; e.is_load = in_is_load;
        e.imm = in_imm;
        e.a   = ref_operand(in_rs1, rf_reg1_data);
        e.b   = ref_operand(in_rs2, rf_reg2_data);
        sb.push_back(e);
      end
      if (flush) m_valid = 1'b0;
      else if (adv) m_valid = acc;
      if (hz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    end
    n_vec++;
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("stall_count", {16'd0, stall_count}, {16'd0, m_cnt});
  endtask

  task automatic idle_inputs();
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_rd = 1'b0; in_is_load = 1'b0; in_imm = '0;
    rf_reg1_data = '0; rf_reg2_data = '0;
    ex_valid = 1'b0; ex_wr_rd = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
    mem_valid = 1'b0; mem_wr_rd = 1'b0; mem_rd = '0; mem_result = '0;
    wb_write_enable = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic rand_inputs();
    reset      = ($urandom_range(0, 299) != 0);
    in_valid   = ($urandom_range(0, 9) < 8);
    in_opcode  = 4'($urandom);
    in_rs1     = 4'($urandom_range(0, 3));
    in_rs2     = 4'($urandom_range(0, 3));
    in_rd      = 4'($urandom);
    in_use_rs1 = 1'($urandom);
    in_use_rs2 = 1'($urandom);
    in_wr_rd   = 1'($urandom);
    in_is_load = 1'($urandom);
    in_imm     = 16'($urandom);
    rf_reg1_data = 16'($urandom);
    rf_reg2_data = 16'($urandom);
    ex_valid   = 1'($urandom);
    ex_wr_rd   = ($urandom_range(0, 3) != 0);
    ex_is_load = ($urandom_range(0, 2) == 0);
    ex_rd      = 4'($urandom_range(0, 3));
    ex_result  = 16'($urandom);
    mem_valid  = 1'($urandom);
    mem_wr_rd  = ($urandom_range(0, 3) != 0);
    mem_rd     = 4'($urandom_range(0, 3));
    mem_result = 16'($urandom);
    wb_write_enable = 1'($urandom);
    wb_write_reg    = 4'($urandom_range(0, 3));
    wb_write_data   = 16'($urandom);
    flush      = ($urandom_range(0, 15) == 0);
    out_ready  = ($urandom_range(0, 9) < 7);
  endtask

  // Monitor: just before each edge, a transfer to EX pops and compares; a flush under hold drops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset === 1'b1 && out_valid === 1'b1 && (out_ready === 1'b1 || flush === 1'b1)) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL monitor: out_valid=1 but no expected instruction queued");
        end else begin
          e = sb.pop_front();
          if (out_ready === 1'b1) begin
            check("out_opcode",  {28'd0, out_opcode}, {28'd0, e.opc});
            check("out_rd",      {28'd0, out_rd}, {28'd0, e.rd});
            check("out_wr_rd",   {31'd0, out_wr_rd}, {31'd0, e.wr_rd});
            check("out_is_load", {31'd0, out_is_load}, {31'd0, e.is_load});
            check("out_imm",     {16'd0, out_imm}, {16'd0, e.imm});
            check("out_op_a",    {16'd0, out_op_a}, {16'd0, e.a});
            check("out_op_b",    {16'd0, out_op_b}, {16'd0, e.b});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_stall_count", {16'd0, stall_count}, 32'd0);
    check("reset_op_a", {16'd0, out_op_a}, 32'd0);

    // 1: plain RF read
    in_valid = 1'b1; in_opcode = 4'd1; in_rs1 = 4'd3; in_rs2 = 4'd3; in_rd = 4'd1;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_wr_rd = 1'b1;
    rf_reg1_data = 16'h1234; rf_reg2_data = 16'h1234;
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_op_a", {16'd0, out_op_a}, 32'h1234);
    check("t1_op_b", {16'd0, out_op_b}, 32'h1234);

    // 2: forwarding priority EX > MEM > WB
    in_rs1 = 4'd5; in_rs2 = 4'd0; rf_reg1_data = 16'h0000;
    ex_valid = 1'b1; ex_wr_rd = 1'b1; ex_is_load = 1'b0; ex_rd = 4'd5; ex_result = 16'h00AA;
    mem_valid = 1'b1; mem_wr_rd = 1'b1; mem_rd = 4'd5; mem_result = 16'h0BBB;
    wb_write_enable = 1'b1; wb_write_reg = 4'd5; wb_write_data = 16'hCCCC;
    tick();
    check("t2_ex", {16'd0, out_op_a}, 32'h00AA);
    ex_valid = 1'b0;
    tick();
    check("t2_mem", {16'd0, out_op_a}, 32'h0BBB);
    mem_valid = 1'b0;
    tick();
    check("t2_wb", {16'd0, out_op_a}, 32'hCCCC);

    // 3: load-use stall then pickup from MEM
    do_reset();
    in_valid = 1'b1; in_rs1 = 4'd0; in_rs2 = 4'd2; in_use_rs1 = 1'b0; in_use_rs2 = 1'b1;
    ex_valid = 1'b1; ex_wr_rd = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd2;
    #1;
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("t3_bubble", {31'd0, out_valid}, 32'd0);
    check("t3_stall", {16'd0, stall_count}, 32'd1);
    ex_valid = 1'b0; mem_valid = 1'b1; mem_wr_rd = 1'b1; mem_rd = 4'd2; mem_result = 16'h7777;
    tick();
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_op_b", {16'd0, out_op_b}, 32'h7777);

    // 4: unused source never stalls
    idle_inputs();
    in_valid = 1'b1; in_rs2 = 4'd2; in_use_rs2 = 1'b0;
    ex_valid = 1'b1; ex_wr_rd = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd2;
    tick();
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_stall", {16'd0, stall_count}, 32'd1);

    // 5: backpressure hold, flush under hold
    idle_inputs();
    in_valid = 1'b1; in_rs1 = 4'd7; in_use_rs1 = 1'b1; rf_reg1_data = 16'h1111; in_imm = 16'h5A5A;
    tick();
    out_ready = 1'b0; rf_reg1_data = 16'h2222; in_imm = 16'h0F0F;
    #1;
    check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
    check("t5_hold_a", {16'd0, out_op_a}, 32'h1111);
    check("t5_hold_imm", {16'd0, out_imm}, 32'h5A5A);
    flush = 1'b1;
    tick();
    check("t5_flush_valid", {31'd0, out_valid}, 32'd0);
    check("t5_flush_imm", {16'd0, out_imm}, 32'h5A5A);
    flush = 1'b0;
    tick();

    // 6: reset mid-stall, then saturation
    do_reset();
    in_valid = 1'b1; in_rs1 = 4'd2; in_use_rs1 = 1'b1;
    ex_valid = 1'b1; ex_wr_rd = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd2;
    for (int i = 0; i < 5; i++) tick();
    check("t6_stall5", {16'd0, stall_count}, 32'h5);
    reset = 1'b0;
    tick();
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_stall", {16'd0, stall_count}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("t6_saturate", {16'd0, stall_count}, 32'hFFFF);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    // drain
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    check("drain_queue_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
